// File: rtl/mbist_march_seq.sv
// March C- address/data sequencer for memory built-in self-test.
// One memory operation per enabled cycle:
//   E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0)
// Optional build macro: MBIST_CHECKERBOARD_EN selects checkerboard data
// backgrounds instead of solid 0x00/0xFF. Sequence timing is the same in both builds.
module mbist_march_seq #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              NbarT,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] exp_data,
  output logic              we,
  output logic              re,
  output logic [2:0]        elem,
  output logic              cout
);

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } elem_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  elem_t             elem_r;
  logic              op_r;
  logic [ADDR_W-1:0] addr_r;
  logic              cout_r;

  logic              last_addr_s;
  logic              active_s;
  logic              is_write_s;
  logic              pol_s;
  logic [DATA_W-1:0] pat_s;

  // Elements with a read followed by a write.
  function automatic logic two_op(input elem_t e);
    case (e)
      E1, E2, E3, E4: two_op = 1'b1;
      default:        two_op = 1'b0;
    endcase
  endfunction

  // Elements that walk the address space from N-1 down to 0.
  function automatic logic is_down(input elem_t e);
    case (e)
      E3, E4:  is_down = 1'b1;
      default: is_down = 1'b0;
    endcase
  endfunction

  // Operation kind: 1 = write, 0 = read.
  function automatic logic op_is_write(input elem_t e, input logic op);
    case (e)
      E0:             op_is_write = 1'b1;
      E1, E2, E3, E4: op_is_write = op;
      default:        op_is_write = 1'b0;
    endcase
  endfunction

  // Data polarity written or expected by the operation.
  function automatic logic op_pol(input elem_t e, input logic op);
    case (e)
      E1, E3:  op_pol = op;
      E2, E4:  op_pol = ~op;
      default: op_pol = 1'b0;
    endcase
  endfunction

  // Successor element in the march order.
  function automatic elem_t next_elem(input elem_t e);
    case (e)
      E0:      next_elem = E1;
      E1:      next_elem = E2;
      E2:      next_elem = E3;
      E3:      next_elem = E4;
      E4:      next_elem = E5;
      default: next_elem = E5;
    endcase
  endfunction

  // Decode the current operation into strobes and data pattern.
  always_comb begin
    pat_s = {DATA_W{1'b0}};
    if (is_down(elem_r)) begin
      last_addr_s = (addr_r == ADDR_ZERO);
    end else begin
      last_addr_s = (addr_r == ADDR_MAX);
    end
    active_s   = NbarT & ~ld & ~cout_r & ~rst;
    is_write_s = op_is_write(elem_r, op_r);
    pol_s      = op_pol(elem_r, op_r);
`ifdef MBIST_CHECKERBOARD_EN
    for (int i = 0; i < DATA_W; i++) begin
      pat_s[i] = pol_s ^ i[0] ^ addr_r[0];
    end
`else
    pat_s = {DATA_W{pol_s}};
`endif
  end

  // Memory strobes and data; held at zero while reset is asserted.
  always_comb begin
    we = active_s & is_write_s;
    re = active_s & ~is_write_s;
    if (rst) begin
      wdata    = {DATA_W{1'b0}};
      exp_data = {DATA_W{1'b0}};
    end else begin
      wdata    = pat_s;
      exp_data = pat_s;
    end
  end

  // Sequence position: reset/load restart, otherwise step one operation per enabled edge.
  always_ff @(posedge clk) begin
    if (rst || ld) begin
      elem_r <= E0;
      op_r   <= 1'b0;
      addr_r <= ADDR_ZERO;
      cout_r <= 1'b0;
    end else if (NbarT && !cout_r) begin
      if (two_op(elem_r) && !op_r) begin
        op_r <= 1'b1;
      end else if (!last_addr_s) begin
        op_r <= 1'b0;
        if (is_down(elem_r)) begin
          addr_r <= addr_r - ADDR_ONE;
        end else begin
          addr_r <= addr_r + ADDR_ONE;
        end
      end else if (elem_r == E5) begin
        cout_r <= 1'b1;
      end else begin
        elem_r <= next_elem(elem_r);
        op_r   <= 1'b0;
        if (is_down(next_elem(elem_r))) begin
          addr_r <= ADDR_MAX;
        end else begin
          addr_r <= ADDR_ZERO;
        end
      end
    end else begin
      elem_r <= elem_r;
      op_r   <= op_r;
      addr_r <= addr_r;
      cout_r <= cout_r;
    end
  end

  assign addr = addr_r;
  assign elem = elem_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_mbist_march_seq.sv
// Scoreboard bench for mbist_march_seq: a reference list of all March C-
// operations is built from the element table; each cycle the driver pushes
// the expected outputs and a negedge monitor pops and compares.
module tb_mbist_march_seq;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int N      = 2 ** ADDR_W;
  localparam int NOPS   = 10 * N;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_data;
    logic              we;
    logic              re;
    logic [2:0]        elem;
    logic              cout;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst, ld, NbarT;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, exp_data;
  logic              we, re, cout;
  logic [2:0]        elem;

  mbist_march_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .ld(ld), .NbarT(NbarT),
    .addr(addr), .wdata(wdata), .exp_data(exp_data),
    .we(we), .re(re), .elem(elem), .cout(cout)
  );

  always #5 clk = ~clk;

  // Reference operation list
  int op_addr [NOPS];
  int op_elem [NOPS];
  bit op_w    [NOPS];
  bit op_pol  [NOPS];

  // Model state: number of operations completed since last restart
  int k;
  bit model_valid;
  bit prev_rst, prev_ld, prev_n;

  obs_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  function automatic obs_t expect_of(bit r, bit l, bit n);
    obs_t e;
    bit done, act, w, p;
    int a;
    done = (k == NOPS);
    a    = done ? N - 1 : op_addr[k];
    w    = done ? 1'b0 : op_w[k];
    p    = done ? 1'b0 : op_pol[k];
    act  = n & ~l & ~r & ~done;
    e.addr = a[ADDR_W-1:0];
    e.elem = done ? 3'd5 : 3'(op_elem[k]);
    e.cout = done;
    e.we   = act & w;
    e.re   = act & ~w;
    for (int i = 0; i < DATA_W; i++) begin
`ifdef MBIST_CHECKERBOARD_EN
      e.wdata[i] = r ? 1'b0 : (p ^ i[0] ^ a[0]);
`else
      e.wdata[i] = r ? 1'b0 : p;
`endif
    end
    e.exp_data = e.wdata;
    return e;
  endfunction

  task automatic step(input bit r, input bit l, input bit n);
    @(posedge clk);
    if (prev_rst || prev_ld) begin
      k = 0;
      model_valid = 1'b1;
    end else if (model_valid && prev_n && k < NOPS) begin
      k = k + 1;
    end
    #1;
    rst = r; ld = l; NbarT = n;
    prev_rst = r; prev_ld = l; prev_n = n;
    if (model_valid) exp_q.push_back(expect_of(r, l, n));
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    obs_t got, want;
    cyc = cyc + 1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = '{addr, wdata, exp_data, we, re, elem, cout};
      checks = checks + 1;
      if (got !== want) begin
        errors = errors + 1;
        $display("FAIL outputs cyc=%0d got addr=%h wd=%h ed=%h we=%b re=%b elem=%0d cout=%b required addr=%h wd=%h ed=%h we=%b re=%b elem=%0d cout=%b",
                 cyc, got.addr, got.wdata, got.exp_data, got.we, got.re, got.elem, got.cout,
                 want.addr, want.wdata, want.exp_data, want.we, want.re, want.elem, want.cout);
      end
    end
  end

  int nops_t [6] = '{1, 2, 2, 2, 2, 1};
  bit down_t [6] = '{0, 0, 0, 1, 1, 0};
  bit w_t    [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  bit v_t    [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  initial begin
    int idx;
    idx = 0;
    for (int e = 0; e < 6; e++) begin
      for (int a = 0; a < N; a++) begin
        for (int j = 0; j < nops_t[e]; j++) begin
          op_addr[idx] = down_t[e] ? (N - 1 - a) : a;
          op_elem[idx] = e;
          op_w[idx]    = w_t[e][j];
          op_pol[idx]  = v_t[e][j];
          idx++;
        end
      end
    end

    k = 0; model_valid = 1'b0;
    rst = 1'b1; ld = 1'b0; NbarT = 1'b0;
    prev_rst = 1'b1; prev_ld = 1'b0; prev_n = 1'b0;

    // Reset held, including with NbarT high
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    // Load, then full run past completion and hold
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 170; i++) step(1'b0, 1'b0, 1'b1);
    // Load while complete
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    // Stall mid-E2
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 55; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
    // Abort during E4
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 125; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    // Randomized enable with rare load/reset
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mbist_march_seq.md
MBIST_MARCH_SEQ -- requirements
Module: mbist_march_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, memory address width; N = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ld  input  1  load/clear from the test controller; active-high.
REQ-006 SHALL have port NbarT  input  1  count enable from the test controller; 1 = test mode.
REQ-007 SHALL have port addr  output  ADDR_W  memory address of the current operation.
REQ-008 SHALL have port wdata  output  DATA_W  write data for the current operation.
REQ-009 SHALL have port exp_data  output  DATA_W  expected read data for the current operation.
REQ-010 SHALL have port we  output  1  memory write strobe.
REQ-011 SHALL have port re  output  1  memory read strobe.
REQ-012 SHALL have port elem  output  3  current march element index, 0..5.
REQ-013 SHALL have port cout  output  1  sequence-complete flag, returned to the test controller.

Function
REQ-014 SHALL run the March C- sequence, one operation per enabled cycle: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-015 SHALL hold the sequence position in registered state: elem (3 b), op index (1 b, 0 = first operation of the element) and address (ADDR_W b).
REQ-016 SHALL give ld priority over NbarT: when ld=1, the next edge sets elem=0, op=0, addr=0 and cout=0.
REQ-017 SHALL advance exactly one operation per edge when ld=0, NbarT=1 and cout=0; when NbarT=0, all state SHALL be frozen.
REQ-018 SHALL advance within an element as: op 0 to op 1 for two-operation elements; otherwise step the address (+1 for up elements, -1 for down elements) and set op=0.
REQ-019 SHALL, at the last operation of the last address of an element, move to elem+1 with op=0; the start address SHALL be 0 for up elements and N-1 for down elements.
REQ-020 SHALL, at the last operation of E5 (addr=N-1), set cout=1 on that edge; cout SHALL stay 1 until ld or rst, and state SHALL freeze.
REQ-021 SHALL drive we and re combinationally: active = NbarT & ~ld & ~cout; we = active & (current op is a write); re = active & (current op is a read); we and re SHALL never both be 1.
REQ-022 SHALL set polarity p to the value written (wN) or expected (rN) by the current op; without the macro, wdata and exp_data SHALL have all bits equal to p.
REQ-023 SHALL complete the full sequence in 10*N enabled cycles (160 for ADDR_W=4), with no address wrap beyond 0..N-1.
REQ-024 SHALL drive addr and elem directly from the state registers, valid in every cycle.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set elem=0, op=0, addr=0 and cout=0; rst SHALL override ld and NbarT.
REQ-026 SHALL, with rst=1 held, have outputs we=0, re=0, wdata=0, exp_data=0, addr=0, elem=0 and cout=0 one edge after rst is applied.
REQ-027 SHALL treat rst or ld asserted mid-sequence (any element, including while cout=1) as an abort back to the start of E0.

Configuration
REQ-028 SHALL, with macro MBIST_CHECKERBOARD_EN defined, set data bit i = p ^ i[0] ^ addr[0] for wdata and exp_data, giving 0xAA for w0 at even addresses and 0x55 for w0 at odd addresses (DATA_W=8).
REQ-029 SHALL, without MBIST_CHECKERBOARD_EN, use solid backgrounds only (0x00/0xFF); sequence timing SHALL be identical in both builds.

Verification
REQ-030 SHALL cover reset: rst=1 for 1 edge -> addr=0, elem=0, cout=0, we=0, re=0.
REQ-031 SHALL cover sequence start: ld pulse, then NbarT=1 -> cycle 1 we=1, addr=0, wdata=0x00; cycle 17 re=1, addr=0, exp_data=0x00; cycle 18 we=1, wdata=0xFF.
REQ-032 SHALL cover the down element: at elem 3, first op -> addr=15, re=1, exp_data=0x00; addr SHALL decrement to 0.
REQ-033 SHALL cover the full run: 160 enabled cycles -> cout=1 from cycle 161, held with we=re=0 until ld=1; one edge after ld, cout=0 and addr=0.
REQ-034 SHALL cover the stall: NbarT=0 for 5 cycles mid-E2 -> addr, elem and op unchanged, we=re=0; the sequence resumes at the same operation.
REQ-035 SHALL cover abort: ld=1 with NbarT=1 at elem 4 -> next edge elem=0, addr=0; with MBIST_CHECKERBOARD_EN, the E0 write at addr 1 SHALL give wdata=0x55.
